// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch/PC control: load-use bubbles, branch squash and debug run/step/halt sequencing.
// Define PIPE_CYCLE_COUNT_EN to add o_cycle_count, a saturating count of active cycles.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int BITS_REGS    = 5,
  parameter int CNT_BITS     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_run,
  input  logic                 i_step_req,
  input  logic                 i_restart,
  input  logic                 i_ex_mem_read,
  input  logic [BITS_REGS-1:0] i_ex_rt,
  input  logic [BITS_REGS-1:0] i_id_rs,
  input  logic [BITS_REGS-1:0] i_id_rt,
  input  logic                 i_id_uses_rt,
  input  logic                 i_id_halt,
  input  logic                 i_branch_taken,
  output logic                 o_pc_write,
  output logic                 o_ifid_step,
  output logic                 o_ifid_flush,
  output logic                 o_idex_step,
  output logic                 o_idex_flush,
  output logic [CNT_BITS-1:0]  o_stall_count,
  output logic                 o_halted,
  output logic [2:0]           o_state
`ifdef PIPE_CYCLE_COUNT_EN
  ,
  output logic [31:0]          o_cycle_count
`endif
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t              r_state;
  logic [DW-1:0]       r_drain;
  logic [CNT_BITS-1:0] r_stall;
  logic                r_halted;

  logic w_issue;
  logic w_active;
  logic w_hz;
  logic w_stall;
  logic w_halt;

  // RUN/STEP are the states that accept new instructions; DRAIN only pushes bubbles.
  assign w_issue  = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_active = w_issue || (r_state == S_DRAIN);

  assign w_hz = i_ex_mem_read && (i_ex_rt != '0) &&
                ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

  assign w_stall = w_issue && !i_branch_taken && w_hz;
  assign w_halt  = w_issue && i_id_halt && !i_branch_taken && !w_hz;

  always_comb begin
    o_pc_write   = 1'b0;
    o_ifid_step  = 1'b0;
    o_ifid_flush = 1'b0;
    o_idex_step  = 1'b0;
    o_idex_flush = 1'b0;
    if (r_state == S_DRAIN) begin
      o_idex_step  = 1'b1;
      o_idex_flush = 1'b1;
    end else if (w_issue) begin
      if (i_branch_taken) begin
        o_pc_write   = 1'b1;
        o_ifid_step  = 1'b1;
        o_ifid_flush = 1'b1;
        o_idex_step  = 1'b1;
        o_idex_flush = 1'b1;
      end else if (w_hz) begin
        o_idex_step  = 1'b1;
        o_idex_flush = 1'b1;
      end else begin
        o_pc_write  = 1'b1;
        o_ifid_step = 1'b1;
        o_idex_step = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_drain  <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run)           r_state <= S_RUN;
          else if (i_step_req) r_state <= S_STEP;
        end
        S_RUN, S_STEP: begin
          if (w_halt) begin
            r_state <= S_DRAIN;
            r_drain <= DRAIN_LOAD;
          end else if (r_state == S_STEP) begin
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (r_drain == '0) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_drain <= r_drain - DW'(1);
          end
        end
        S_HALTED: begin
          if (i_restart) begin
            r_state  <= S_IDLE;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stall <= '0;
    end else if (w_stall && (r_stall != {CNT_BITS{1'b1}})) begin
      r_stall <= r_stall + CNT_BITS'(1);
    end
  end

  assign o_stall_count = r_stall;
  assign o_halted      = r_halted;
  assign o_state       = r_state;

`ifdef PIPE_CYCLE_COUNT_EN
  logic [31:0] r_cycles;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cycles <= '0;
    end else if (w_active && (r_cycles != 32'hFFFF_FFFF)) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign o_cycle_count = r_cycles;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle model comparison plus directed literal checks.
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN_CYCLES = 3;
  localparam int BITS_REGS    = 5;
  localparam int CNT_BITS     = 16;

  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALTED = 4;

  logic                 i_clk = 1'b0;
  logic                 i_reset_n;
  logic                 i_run, i_step_req, i_restart;
  logic                 i_ex_mem_read;
  logic [BITS_REGS-1:0] i_ex_rt, i_id_rs, i_id_rt;
  logic                 i_id_uses_rt, i_id_halt, i_branch_taken;
  logic                 o_pc_write, o_ifid_step, o_ifid_flush, o_idex_step, o_idex_flush;
  logic [CNT_BITS-1:0]  o_stall_count;
  logic                 o_halted;
  logic [2:0]           o_state;
`ifdef PIPE_CYCLE_COUNT_EN
  logic [31:0]          o_cycle_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES(DRAIN_CYCLES), .BITS_REGS(BITS_REGS), .CNT_BITS(CNT_BITS)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_run(i_run), .i_step_req(i_step_req),
    .i_restart(i_restart), .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_uses_rt(i_id_uses_rt),
    .i_id_halt(i_id_halt), .i_branch_taken(i_branch_taken),
    .o_pc_write(o_pc_write), .o_ifid_step(o_ifid_step), .o_ifid_flush(o_ifid_flush),
    .o_idex_step(o_idex_step), .o_idex_flush(o_idex_flush),
    .o_stall_count(o_stall_count), .o_halted(o_halted), .o_state(o_state)
`ifdef PIPE_CYCLE_COUNT_EN
    , .o_cycle_count(o_cycle_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Model: mode plus "drain cycles still to go"; stalls and active cycles counted directly.
  int          m_mode;
  int          m_drain_left;
  int unsigned m_stalls;
  longint      m_cycles;

  function automatic logic load_use(input logic mr, input logic [BITS_REGS-1:0] ex_rt,
                                    input logic [BITS_REGS-1:0] rs, input logic [BITS_REGS-1:0] rt,
                                    input logic uses_rt);
    return mr && (ex_rt != 0) && (ex_rt == rs || (uses_rt && ex_rt == rt));
  endfunction

  // {pc_write, ifid_step, ifid_flush, idex_step, idex_flush}
  function automatic logic [4:0] model_en(input int mode, input logic br, input logic hz);
    if (mode == M_DRAIN) return 5'b00011;
    if (mode != M_RUN && mode != M_STEP) return 5'b00000;
    if (br) return 5'b11111;
    if (hz) return 5'b00011;
    return 5'b11010;
  endfunction

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m_mode = M_IDLE; m_drain_left = 0; m_stalls = 0; m_cycles = 0;
    end else begin
      logic hz;
      hz = load_use(i_ex_mem_read, i_ex_rt, i_id_rs, i_id_rt, i_id_uses_rt);
      if (m_mode == M_RUN || m_mode == M_STEP || m_mode == M_DRAIN) begin
        if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
      end
      if (m_mode == M_IDLE) begin
        if (i_run) m_mode = M_RUN;
        else if (i_step_req) m_mode = M_STEP;
      end else if (m_mode == M_RUN || m_mode == M_STEP) begin
        if (!i_branch_taken && hz && m_stalls < (2**CNT_BITS - 1)) m_stalls++;
        if (i_id_halt && !i_branch_taken && !hz) begin
          m_mode = M_DRAIN;
          m_drain_left = DRAIN_CYCLES;
        end else if (m_mode == M_STEP) begin
          m_mode = M_IDLE;
        end
      end else if (m_mode == M_DRAIN) begin
        m_drain_left--;
        if (m_drain_left == 0) m_mode = M_HALTED;
      end else if (m_mode == M_HALTED) begin
        if (i_restart) m_mode = M_IDLE;
      end
    end
  end

  // Per-cycle compare, 2 time units after inputs change on the falling edge.
  always @(negedge i_clk) begin
    logic [24:0] exp_v, act_v;
    #2;
    exp_v = {model_en(m_mode, i_branch_taken,
                      load_use(i_ex_mem_read, i_ex_rt, i_id_rs, i_id_rt, i_id_uses_rt)),
             (m_mode == M_HALTED), 3'(m_mode), 16'(m_stalls)};
    act_v = {o_pc_write, o_ifid_step, o_ifid_flush, o_idex_step, o_idex_flush,
             o_halted, o_state, o_stall_count};
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, act_v, exp_v);
    end
`ifdef PIPE_CYCLE_COUNT_EN
    n_checks++;
    if (o_cycle_count !== 32'(m_cycles)) begin
      n_errors++;
      $display("FAIL cycle_count t=%0t got=%0d expected=%0d", $time, o_cycle_count, m_cycles);
    end
`endif
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp_v);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic lit_en(input string name, input logic [4:0] exp_v);
    lit(name, {27'd0, o_pc_write, o_ifid_step, o_ifid_flush, o_idex_step, o_idex_flush},
        {27'd0, exp_v});
  endtask

  // Apply one cycle's inputs on the falling edge, then settle.
  task automatic drv(input logic run, input logic step, input logic rst_req, input logic mr,
                     input int ex_rt, input int rs, input int rt, input logic uses_rt,
                     input logic halt, input logic br);
    @(negedge i_clk);
    i_run = run; i_step_req = step; i_restart = rst_req; i_ex_mem_read = mr;
    i_ex_rt = BITS_REGS'(ex_rt); i_id_rs = BITS_REGS'(rs); i_id_rt = BITS_REGS'(rt);
    i_id_uses_rt = uses_rt; i_id_halt = halt; i_branch_taken = br;
    #1;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_run = 0; i_step_req = 0; i_restart = 0; i_ex_mem_read = 0;
    i_ex_rt = 0; i_id_rs = 0; i_id_rt = 0; i_id_uses_rt = 0; i_id_halt = 0; i_branch_taken = 0;
    repeat (2) @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    lit("reset_state", 32'(o_state), 0);
    lit_en("reset_enables", 5'b00000);
    lit("reset_stall", 32'(o_stall_count), 0);
    lit("reset_halted", 32'(o_halted), 0);

    drv(1,0,0, 0,0,0,0,0, 0,0); lit_en("idle_no_enables", 5'b00000);
    drv(0,0,0, 1,5,5,0,0, 0,0); lit_en("loaduse_bubble", 5'b00011);
    lit("run_state", 32'(o_state), 1);
    drv(0,0,0, 0,0,0,0,0, 0,0); lit_en("after_bubble", 5'b11010);
    lit("stall_count_1", 32'(o_stall_count), 1);
    drv(0,0,0, 1,0,0,0,0, 0,0); lit_en("rt0_no_stall", 5'b11010);
    drv(0,0,0, 1,7,3,7,1, 0,0); lit("rt0_count_held", 32'(o_stall_count), 1);
    lit_en("rt_use_stall", 5'b00011);
    drv(0,0,0, 1,7,3,7,0, 0,0); lit_en("rt_unused_no_stall", 5'b11010);
    lit("stall_count_2", 32'(o_stall_count), 2);
    drv(0,0,0, 1,5,5,0,0, 0,1); lit_en("branch_over_hz", 5'b11111);
    drv(0,0,0, 1,5,5,0,0, 1,0); lit("branch_no_count", 32'(o_stall_count), 2);
    lit_en("halt_blocked_by_hz", 5'b00011);
    drv(0,1,0, 0,0,0,0,0, 1,0); lit("halt_blocked_state", 32'(o_state), 1);
    lit_en("halt_latches", 5'b11010);
    lit("stall_count_3", 32'(o_stall_count), 3);
    for (int k = 0; k < DRAIN_CYCLES; k++) begin
      drv(1,1,0, 0,0,0,0,0, 0,0);
      lit($sformatf("drain%0d_state", k), 32'(o_state), 3);
      lit_en($sformatf("drain%0d_enables", k), 5'b00011);
    end
    drv(1,1,0, 0,0,0,0,0, 0,0); lit("halted_state", 32'(o_state), 4);
    lit("halted_flag", 32'(o_halted), 1);
    lit_en("halted_enables", 5'b00000);
    drv(0,0,1, 0,0,0,0,0, 0,0); lit("halted_ignores_run", 32'(o_state), 4);
    drv(0,1,0, 0,0,0,0,0, 0,0); lit("restart_to_idle", 32'(o_state), 0);
    lit("restart_halted_clr", 32'(o_halted), 0);
    drv(0,0,0, 0,0,0,0,0, 0,0); lit("step_state", 32'(o_state), 2);
    lit_en("step_enables", 5'b11010);
    drv(0,0,0, 0,0,0,0,0, 0,0); lit("step_back_idle", 32'(o_state), 0);
    lit_en("step_one_cycle", 5'b00000);

    drv(1,0,0, 0,0,0,0,0, 0,0);
    drv(0,0,0, 0,0,0,0,0, 1,0); lit("run2_state", 32'(o_state), 1);
    drv(0,0,0, 0,0,0,0,0, 0,0); lit("run2_drain1", 32'(o_state), 3);
    drv(0,0,0, 0,0,0,0,0, 0,0); lit("run2_drain2", 32'(o_state), 3);
    #2;
    i_reset_n = 1'b0;
    #1;
    lit_en("async_reset_enables", 5'b00000);
    lit("async_reset_state", 32'(o_state), 0);
    lit("async_reset_stall", 32'(o_stall_count), 0);
    lit("async_reset_halted", 32'(o_halted), 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    lit("post_reset_state", 32'(o_state), 0);
    drv(0,0,0, 0,0,0,0,0, 0,0); lit_en("post_reset_idle", 5'b00000);
    repeat (2) @(negedge i_clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
